// File: rtl/id_hazard_ctrl_if.sv
// rtl/id_hazard_ctrl_if.sv - decode-stage taps and interlock outputs for id_hazard_ctrl
interface id_hazard_ctrl_if #(
    parameter int STALL_W = 32
);
    logic               ds_valid;
    logic               es_allowin;
    logic               rs1_en;
    logic [4:0]         rf_raddr1;
    logic               rs2_en;
    logic [4:0]         rf_raddr2;
    logic               ds_gr_we;
    logic [4:0]         ds_dest;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic               ds_ready_go;
    logic               byp_sel1;
    logic               byp_sel2;
    logic [31:0]        busy_mask;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output ds_valid, es_allowin, rs1_en, rf_raddr1, rs2_en, rf_raddr2,
               ds_gr_we, ds_dest, rf_we, rf_waddr,
        input  ds_ready_go, byp_sel1, byp_sel2, busy_mask, stall_cnt
    );

    modport slave (
        input  ds_valid, es_allowin, rs1_en, rf_raddr1, rs2_en, rf_raddr2,
               ds_gr_we, ds_dest, rf_we, rf_waddr,
        output ds_ready_go, byp_sel1, byp_sel2, busy_mask, stall_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - per-GPR pending-write scoreboard and ID interlock
// Optional write-back bypass enabled by defining WB_BYPASS_EN.
module id_hazard_ctrl #(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    id_hazard_ctrl_if.slave   hz
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               issue, retire, src1_busy, src2_busy;
    logic               byp1, byp2, haz1, haz2, full, ready_go;
    logic [31:0]        busy;

    always_comb begin
        retire    = hz.rf_we & (hz.rf_waddr != 5'd0);
        src1_busy = hz.rs1_en & (hz.rf_raddr1 != 5'd0) & (cnt_q[hz.rf_raddr1] != '0);
        src2_busy = hz.rs2_en & (hz.rf_raddr2 != 5'd0) & (cnt_q[hz.rf_raddr2] != '0);
`ifdef WB_BYPASS_EN
        // Last outstanding write lands this cycle: take rf_wdata instead of stalling.
        byp1 = src1_busy & (cnt_q[hz.rf_raddr1] == CNT_ONE) & retire & (hz.rf_waddr == hz.rf_raddr1);
        byp2 = src2_busy & (cnt_q[hz.rf_raddr2] == CNT_ONE) & retire & (hz.rf_waddr == hz.rf_raddr2);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        haz1     = src1_busy & ~byp1;
        haz2     = src2_busy & ~byp2;
        full     = hz.ds_gr_we & (hz.ds_dest != 5'd0) & (cnt_q[hz.ds_dest] == CNT_MAX);
        ready_go = ~haz1 & ~haz2 & ~full;
        issue    = hz.ds_valid & ready_go & hz.es_allowin & hz.ds_gr_we & (hz.ds_dest != 5'd0);
    end

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            busy[r]  = 1'b0;
            if (r != 0) begin
                busy[r] = (cnt_q[r] != '0);
                if (issue && hz.ds_dest == 5'(r) && !(retire && hz.rf_waddr == 5'(r)))
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                else if (retire && hz.rf_waddr == 5'(r) && !(issue && hz.ds_dest == 5'(r))
                         && cnt_q[r] != '0)
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        stall_d = stall_q;
        if (hz.ds_valid && !ready_go && stall_q != '1)
            stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= '0;
            stall_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= cnt_d[r];
            stall_q <= stall_d;
        end
    end

    assign hz.ds_ready_go = ready_go;
    assign hz.byp_sel1    = byp1;
    assign hz.byp_sel2    = byp2;
    assign hz.busy_mask   = busy;
    assign hz.stall_cnt   = stall_q;

    // A retire with nothing outstanding means the pipeline lost track of a write.
    a_no_orphan_retire: assert property (@(posedge clk) disable iff (reset)
        (hz.rf_we && hz.rf_waddr != 5'd0) |-> (cnt_q[hz.rf_waddr] != '0));
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - scoreboard bench for id_hazard_ctrl
module tb_id_hazard_ctrl;
    typedef struct {
        logic        rg;
        logic        b1;
        logic        b2;
        logic [31:0] busy;
        logic [31:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mcnt [32];
    logic [31:0] mstall;
    int   pq [$];
    exp_t exp_q [$];

    id_hazard_ctrl_if hz_if ();
    id_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz_if));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        mstall = 32'd0;
        pq.delete();
    endtask

    task automatic cyc(input logic v, input logic allow,
                       input logic r1e, input logic [4:0] a1,
                       input logic r2e, input logic [4:0] a2,
                       input logic gwe, input logic [4:0] dest,
                       input logic we, input logic [4:0] wa);
        exp_t e, o;
        logic s1, s2, ret, fl, iss;
        @(negedge clk);
        hz_if.ds_valid = v;   hz_if.es_allowin = allow;
        hz_if.rs1_en = r1e;   hz_if.rf_raddr1 = a1;
        hz_if.rs2_en = r2e;   hz_if.rf_raddr2 = a2;
        hz_if.ds_gr_we = gwe; hz_if.ds_dest = dest;
        hz_if.rf_we = we;     hz_if.rf_waddr = wa;
        ret = we && wa != 5'd0;
        s1 = r1e && a1 != 5'd0 && mcnt[a1] > 0;
        s2 = r2e && a2 != 5'd0 && mcnt[a2] > 0;
`ifdef WB_BYPASS_EN
        e.b1 = s1 && mcnt[a1] == 1 && ret && wa == a1;
        e.b2 = s2 && mcnt[a2] == 1 && ret && wa == a2;
`else
        e.b1 = 1'b0;
        e.b2 = 1'b0;
`endif
        fl = gwe && dest != 5'd0 && mcnt[dest] == 3;
        e.rg = !(s1 && !e.b1) && !(s2 && !e.b2) && !fl;
        e.busy = 32'd0;
        for (int i = 1; i < 32; i++) e.busy[i] = (mcnt[i] > 0);
        e.stall = mstall;
        exp_q.push_back(e);
        #1;
        o = exp_q.pop_front();
        chk("ready_go", {31'd0, hz_if.ds_ready_go}, {31'd0, o.rg});
        chk("byp_sel1", {31'd0, hz_if.byp_sel1}, {31'd0, o.b1});
        chk("byp_sel2", {31'd0, hz_if.byp_sel2}, {31'd0, o.b2});
        chk("busy_mask", hz_if.busy_mask, o.busy);
        chk("stall_cnt", hz_if.stall_cnt, o.stall);
        iss = v && e.rg && allow && gwe && dest != 5'd0;
        if (ret) begin
            mcnt[wa]--;
            for (int i = 0; i < pq.size(); i++)
                if (pq[i] == int'(wa)) begin pq.delete(i); break; end
        end
        if (iss) begin
            mcnt[dest]++;
            pq.push_back(int'(dest));
        end
        if (v && !e.rg && mstall != 32'hffff_ffff) mstall++;
        @(posedge clk);
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] d, a1, a2, wa;
        logic we;
        reset = 1'b1;
        hz_if.ds_valid = 0; hz_if.es_allowin = 0; hz_if.rs1_en = 0; hz_if.rf_raddr1 = 0;
        hz_if.rs2_en = 0; hz_if.rf_raddr2 = 0; hz_if.ds_gr_we = 0; hz_if.ds_dest = 0;
        hz_if.rf_we = 0; hz_if.rf_waddr = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();

        // RAW on r5: issue, stall 3 cycles, retire, release
        cyc(1, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        repeat (3) cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 1, 5);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        #1;
`ifdef WB_BYPASS_EN
        chk("t2_stall_total", hz_if.stall_cnt, 32'd3);
`else
        chk("t2_stall_total", hz_if.stall_cnt, 32'd4);
`endif

        // r0 is never tracked
        cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);

        // simultaneous issue and retire on r7 keeps count at 1
        cyc(1, 1, 0, 0, 0, 0, 1, 7, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 7, 1, 7);
        #1;
        chk("t3_busy_r7", hz_if.busy_mask, 32'h0000_0080);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 7);

        // counter saturation on r3
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 3, 1, 3);
        cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 3);
        idle();

        // retire r9 in the same cycle ID reads it on source 2
        cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0);
        cyc(1, 1, 0, 0, 1, 9, 0, 0, 1, 9);
        cyc(1, 1, 0, 0, 1, 9, 0, 0, 0, 0);

        // random traffic, in-order retirement of issued writes
        for (int n = 0; n < 400; n++) begin
            we = (pq.size() > 0) && ($urandom_range(0, 2) != 0);
            wa = we ? 5'(pq[0]) : 5'($urandom_range(0, 31));
            d  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
            a1 = 5'($urandom_range(0, 8));
            a2 = 5'($urandom_range(0, 8));
            cyc($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), a2,
                1'($urandom_range(0, 1)), d, we, wa);
        end

        // async reset mid-run with counters live
        cyc(1, 1, 0, 0, 0, 0, 1, 10, 0, 0);
        cyc(1, 1, 1, 10, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("t1_pre_busy10", {31'd0, hz_if.busy_mask[10]}, 32'd1);
        chk("t1_pre_ready", {31'd0, hz_if.ds_ready_go}, 32'd0);
        reset = 1'b1;
        #1;
        chk("t1_busy", hz_if.busy_mask, 32'd0);
        chk("t1_stall", hz_if.stall_cnt, 32'd0);
        chk("t1_ready", {31'd0, hz_if.ds_ready_go}, 32'd1);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 1, 1, 10, 1, 5, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
